fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the RISC-V core: owns the program counter, drives the byte address of the combinational instruction memory, and captures the returned 32-bit little-endian word into the IF/ID pipeline register for decode. It sits directly upstream of the instruction memory and directly upstream of decode. It handles stall, branch/jump redirect with flush, a one-cycle post-reset bubble, and halt on EBREAK.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, word placed in if_id_instr on flush/bubble (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst_n  in  1  reset, synchronous and active-low.
- imem_adr  out  32  byte address to instruction memory; equals PC combinationally.
- imem_rd  in  32  instruction word from memory; combinational, valid in the same cycle as imem_adr.
- stall_i  in  1  hold PC, FSM state and IF/ID contents.
- redirect_i  in  1  taken branch/jump from EX; load the new PC and flush IF/ID.
- redirect_pc_i  in  32  redirect target byte address.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  32  fetched instruction.
- if_id_pc  out  32  PC of if_id_instr.
- if_id_pc4  out  32  if_id_pc + 4 (mod 2^32).
- halted  out  1  FSM is in HALTED.
- misalign_o  out  1  one-cycle pulse: the accepted redirect target had bits [1:0] ≠ 0.

## Operation

- FSM states:
  - BOOT (entered on reset).
  - RUN.
  - HALTED.
- Priority each cycle: reset > redirect_i > stall_i > normal fetch.
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC, state=BOOT.
  - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0.
  - misalign_o=0; halted=0.
  - Reset asserted mid-operation discards everything; there is no partial state.
- BOOT:
  - Lasts exactly one cycle, then goes to RUN.
  - No capture; IF/ID stays the bubble. PC is unchanged unless a redirect occurs.
- Redirect (any state, including BOOT and HALTED, regardless of stall_i):
  - pc <= {redirect_pc_i[31:2],2'b00}; state <= RUN.
  - if_id_valid <= 0, if_id_instr <= NOP_INSTR; if_id_pc and if_id_pc4 hold.
  - misalign_o <= (redirect_pc_i[1:0] ≠ 0).
- Stall (no redirect): pc, state and all IF/ID fields hold; misalign_o <= 0.
- RUN normal fetch (P = current pc):
  - if_id_valid<=1, if_id_instr<=imem_rd, if_id_pc<=P, if_id_pc4<=P+4.
  - If imem_rd == 32'h0010_0073 (EBREAK): pc holds, state <= HALTED.
  - Otherwise pc <= P+4.
- HALTED (no redirect, no stall): pc holds; if_id_valid<=0, if_id_instr<=NOP_INSTR each cycle.
- PC arithmetic:
  - 32-bit, wraps 0xFFFF_FFFC → 0x0000_0000.
  - Memory wrap (10-bit address space) is the memory's concern; fetch does not mask the PC.

## Timing

- Fetch latency: 1 cycle. The word at P appears on if_id_* at the edge ending the cycle in which imem_adr=P.
- Throughput: one instruction per cycle in RUN without stall.
- After rst_n deasserts:
  - First cycle: BOOT, imem_adr=RESET_PC.
  - First valid IF/ID occurs 2 edges after reset release.
- Redirect seen in cycle N: imem_adr = target in cycle N+1; the first target instruction is valid after edge N+1. Exactly one bubble.
- halted rises in the cycle after the EBREAK is captured. EBREAK itself is delivered with if_id_valid=1.
- misalign_o is registered and high for one cycle only.

## Structure

- Shared package riscv_pkg holds:
  - NOP_INSTR and EBREAK_INSTR constants.
  - XLEN=32.
  - The fetch FSM state encoding (BOOT=2'd0, RUN=2'd1, HALTED=2'd2).
- One sub-module: if_id_reg. It holds the four IF/ID fields with load, flush and hold controls.
- PC register, next-PC mux and FSM live in fetch_unit.

## Test plan

- Reset → sequential fetch:
  - Memory = addi words at 0x0, 0x4, 0x8; RESET_PC=0; release rst_n.
  - Required: one bubble cycle, then if_id_pc = 0, 4, 8 with if_id_valid=1 and matching instructions.
- Stall:
  - Assert stall_i for 3 cycles while pc=0x8.
  - Required: imem_adr stays 0x8, IF/ID unchanged; fetch resumes at 0x8 with no skip or duplicate.
- Redirect beats stall:
  - Assert stall_i and redirect_i together with target 0x40.
  - Required: next cycle imem_adr=0x40, if_id_valid=0, if_id_instr=0x13; the next edge captures the word at 0x40.
- Misaligned redirect:
  - Target 0x46.
  - Required: pc=0x44, misalign_o=1 for exactly one cycle.
- EBREAK halt and recovery:
  - 0x0010_0073 at 0xC.
  - Required: captured valid with if_id_pc=0xC; halted=1; if_id_valid=0 thereafter, pc=0xC.
  - Then redirect to 0x0: required halted=0 and fetch resumes from 0x0.
- Reset mid-run and wrap:
  - Pull rst_n low while pc=0x20: required all outputs return to reset values next edge.
  - Separately, RESET_PC=0xFFFF_FFFC: required next pc is 0x0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and the fetch FSM state encoding.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h0010_0073;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, its PC and PC+4, plus a valid flag.
module if_id_reg #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   output logic        valid,
   output logic [31:0] instr_q,
   output logic [31:0] pc_q,
   output logic [31:0] pc4_q
);

   // Flush only turns the slot into a bubble; pc/pc4 keep their last values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid   <= 1'b0;
         instr_q <= NOP_INSTR;
         pc_q    <= 32'h0000_0000;
         pc4_q   <= 32'h0000_0000;
      end else if (flush) begin
         valid   <= 1'b0;
         instr_q <= NOP_INSTR;
      end else if (load) begin
         valid   <= 1'b1;
         instr_q <= instr;
         pc_q    <= pc;
         pc4_q   <= pc + 32'd4;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection, fetch FSM and IF/ID capture.
//
//  state     | meaning
//  ST_BOOT   | one bubble cycle after reset, no capture
//  ST_RUN    | fetch one word per cycle into IF/ID
//  ST_HALTED | EBREAK seen; PC frozen, IF/ID emits bubbles until redirect
module fetch_unit #(
   parameter logic [riscv_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [riscv_pkg::XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_adr,
   input  logic [31:0] imem_rd,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic        halted,
   output logic        misalign_o
);
   import riscv_pkg::*;

   fetch_state_e state, state_nxt;
   logic [31:0]  pc, pc_nxt;
   logic         misalign_nxt;
   logic         load, flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_BOOT;
         pc         <= RESET_PC;
         misalign_o <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         misalign_o <= misalign_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      misalign_nxt = 1'b0;
      load         = 1'b0;
      flush        = 1'b0;
      if (redirect_i) begin
         state_nxt    = ST_RUN;
         pc_nxt       = {redirect_pc_i[31:2], 2'b00};
         misalign_nxt = |redirect_pc_i[1:0];
         flush        = 1'b1;
      end else if (!stall_i) begin
         case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
               load = 1'b1;
               // EBREAK is delivered downstream but the PC parks on it.
               if (imem_rd == EBREAK_INSTR) state_nxt = ST_HALTED;
               else                         pc_nxt    = pc + 32'd4;
            end
            ST_HALTED: flush = 1'b1;
            default:   state_nxt = ST_BOOT;
         endcase
      end
   end

   assign imem_adr = pc;
   assign halted   = (state == ST_HALTED);

   if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .flush   (flush),
      .pc      (pc),
      .instr   (imem_rd),
      .valid   (if_id_valid),
      .instr_q (if_id_instr),
      .pc_q    (if_id_pc),
      .pc4_q   (if_id_pc4)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a cycle-level behavioural model.
module tb_fetch_unit;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_adr, imem_rd;
   logic        stall_i, redirect_i;
   logic [31:0] redirect_pc_i;
   logic        if_id_valid, halted, misalign_o;
   logic [31:0] if_id_instr, if_id_pc, if_id_pc4;

   logic        w_rst_n;
   logic [31:0] w_adr, w_rd;
   logic        w_valid, w_halted, w_mis;
   logic [31:0] w_instr, w_pc, w_pc4;

   logic [31:0] mem [0:255];

   int errors = 0;
   int checks = 0;

   // behavioural model: mode 0=boot, 1=run, 2=halted
   int          m_mode;
   logic [31:0] m_pc, m_instr, m_ipc, m_pc4;
   logic        m_valid, m_mis;

   always #5 clk = ~clk;

   assign imem_rd = mem[imem_adr[9:2]];
   assign w_rd    = mem[w_adr[9:2]];

   fetch_unit u_dut (
      .clk(clk), .rst_n(rst_n), .imem_adr(imem_adr), .imem_rd(imem_rd),
      .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
      .if_id_pc4(if_id_pc4), .halted(halted), .misalign_o(misalign_o)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(w_rst_n), .imem_adr(w_adr), .imem_rd(w_rd),
      .stall_i(1'b0), .redirect_i(1'b0), .redirect_pc_i(32'h0),
      .if_id_valid(w_valid), .if_id_instr(w_instr), .if_id_pc(w_pc),
      .if_id_pc4(w_pc4), .halted(w_halted), .misalign_o(w_mis)
   );

   wire [130:0] dut_vec = {imem_adr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4,
                           halted, misalign_o};

   function automatic logic [130:0] exp_vec();
      return {m_pc, m_valid, m_instr, m_ipc, m_pc4, (m_mode == 2), m_mis};
   endfunction

   // Advance the model by one edge from the current inputs, then clock the DUT.
   task automatic tick();
      logic [31:0] w;
      w = mem[m_pc[9:2]];
      if (!rst_n) begin
         m_mode = 0; m_pc = 32'h0; m_valid = 0; m_instr = NOP;
         m_ipc = 0; m_pc4 = 0; m_mis = 0;
      end else if (redirect_i) begin
         m_mode  = 1;
         m_pc    = redirect_pc_i & 32'hFFFF_FFFC;
         m_valid = 0;
         m_instr = NOP;
         m_mis   = (redirect_pc_i % 4) != 0;
      end else if (stall_i) begin
         m_mis = 0;
      end else begin
         m_mis = 0;
         if (m_mode == 0) m_mode = 1;
         else if (m_mode == 1) begin
            m_valid = 1; m_instr = w; m_ipc = m_pc; m_pc4 = m_pc + 4;
            if (w == EBREAK) m_mode = 2;
            else m_pc = m_pc + 4;
         end else begin
            m_valid = 0; m_instr = NOP;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
      tick();
      tick();
      checks++;
      if (dut_vec !== {32'h0, 1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got %h want %h", dut_vec,
                  {32'h0, 1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b0});
      end
   endtask

   task automatic test_seq_stall_halt();
      rst_n = 1;
      tick();
      checks++;
      if (if_id_valid !== 1'b0 || imem_adr !== 32'h0) begin
         errors++;
         $display("FAIL boot_bubble: got valid=%b adr=%h want valid=0 adr=0", if_id_valid, imem_adr);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4*i) || if_id_instr !== mem[i]) begin
            errors++;
            $display("FAIL seq_fetch%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                     i, if_id_valid, if_id_pc, if_id_instr, 32'(4*i), mem[i]);
         end
      end
      stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (imem_adr !== 32'h8 || if_id_pc !== 32'h4 || if_id_instr !== mem[1]) begin
            errors++;
            $display("FAIL stall_hold%0d: got adr=%h pc=%h ins=%h want adr=8 pc=4 ins=%h",
                     i, imem_adr, if_id_pc, if_id_instr, mem[1]);
         end
      end
      stall_i = 0;
      tick();
      checks++;
      if (if_id_pc !== 32'h8 || if_id_instr !== mem[2] || if_id_pc4 !== 32'hC) begin
         errors++;
         $display("FAIL stall_resume: got pc=%h ins=%h pc4=%h want pc=8 ins=%h pc4=c",
                  if_id_pc, if_id_instr, if_id_pc4, mem[2]);
      end
      tick();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'hC || if_id_instr !== EBREAK || halted !== 1'b1) begin
         errors++;
         $display("FAIL ebreak_capture: got v=%b pc=%h ins=%h halted=%b want v=1 pc=c ins=%h halted=1",
                  if_id_valid, if_id_pc, if_id_instr, halted, EBREAK);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_adr !== 32'hC || halted !== 1'b1) begin
            errors++;
            $display("FAIL halted_hold%0d: got v=%b ins=%h adr=%h halted=%b want v=0 ins=13 adr=c halted=1",
                     i, if_id_valid, if_id_instr, imem_adr, halted);
         end
      end
      redirect_i = 1; redirect_pc_i = 32'h0;
      tick();
      redirect_i = 0;
      checks++;
      if (halted !== 1'b0 || imem_adr !== 32'h0 || if_id_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_recover: got halted=%b adr=%h v=%b want halted=0 adr=0 v=0",
                  halted, imem_adr, if_id_valid);
      end
      tick();
      checks++;
      if (dut_vec !== exp_vec() || if_id_pc !== 32'h0 || if_id_valid !== 1'b1) begin
         errors++;
         $display("FAIL recover_fetch: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_redirect_stall();
      stall_i = 1; redirect_i = 1; redirect_pc_i = 32'h40;
      tick();
      stall_i = 0; redirect_i = 0;
      checks++;
      if (imem_adr !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== NOP || misalign_o !== 1'b0) begin
         errors++;
         $display("FAIL redirect_beats_stall: got adr=%h v=%b ins=%h mis=%b want adr=40 v=0 ins=13 mis=0",
                  imem_adr, if_id_valid, if_id_instr, misalign_o);
      end
      tick();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40 || if_id_instr !== mem[16]) begin
         errors++;
         $display("FAIL redirect_target: got v=%b pc=%h ins=%h want v=1 pc=40 ins=%h",
                  if_id_valid, if_id_pc, if_id_instr, mem[16]);
      end
   endtask

   task automatic test_misalign();
      redirect_i = 1; redirect_pc_i = 32'h46;
      tick();
      redirect_i = 0;
      checks++;
      if (imem_adr !== 32'h44 || misalign_o !== 1'b1) begin
         errors++;
         $display("FAIL misalign_pulse: got adr=%h mis=%b want adr=44 mis=1", imem_adr, misalign_o);
      end
      tick();
      checks++;
      if (misalign_o !== 1'b0 || if_id_pc !== 32'h44 || dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL misalign_one_cycle: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         stall_i       = ($urandom_range(0, 3) == 0);
         redirect_i    = ($urandom_range(0, 9) == 0);
         redirect_pc_i = ($urandom_range(0, 4) == 0) ? $urandom : $urandom_range(0, 1023);
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
      stall_i = 0; redirect_i = 0;
   endtask

   task automatic test_reset_mid();
      redirect_i = 1; redirect_pc_i = 32'h20;
      tick();
      tick();
      redirect_i = 0;
      tick();
      checks++;
      if (imem_adr !== 32'h24 || if_id_pc !== 32'h20) begin
         errors++;
         $display("FAIL pre_reset_run: got adr=%h pc=%h want adr=24 pc=20", imem_adr, if_id_pc);
      end
      rst_n = 0;
      tick();
      checks++;
      if (dut_vec !== {32'h0, 1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_run: got %h want %h", dut_vec,
                  {32'h0, 1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b0});
      end
      rst_n = 1;
   endtask

   task automatic test_wrap();
      w_rst_n = 0;
      @(posedge clk); #1;
      w_rst_n = 1;
      @(posedge clk); #1;
      checks++;
      if (w_adr !== 32'hFFFF_FFFC || w_valid !== 1'b0) begin
         errors++;
         $display("FAIL wrap_boot: got adr=%h v=%b want adr=fffffffc v=0", w_adr, w_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (w_adr !== 32'h0 || w_pc !== 32'hFFFF_FFFC || w_pc4 !== 32'h0 || w_instr !== mem[255]) begin
         errors++;
         $display("FAIL wrap_pc: got adr=%h pc=%h pc4=%h ins=%h want adr=0 pc=fffffffc pc4=0 ins=%h",
                  w_adr, w_pc, w_pc4, w_instr, mem[255]);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom;
         if (mem[i] == EBREAK) mem[i] = mem[i] ^ 32'h1;
      end
      mem[0]   = 32'h0010_0093;
      mem[1]   = 32'h0020_0113;
      mem[2]   = 32'h0030_0193;
      mem[3]   = EBREAK;
      mem[255] = 32'h0040_0213;
      for (int i = 0; i < 4; i++) mem[100 + $urandom_range(0, 40)] = EBREAK;
      w_rst_n = 0;
      test_reset();
      test_seq_stall_halt();
      test_redirect_stall();
      test_misalign();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
